apb_rr_master_arb: RTL

//  Shares one APB master port between NREQ on-chip requesters using fair round-robin arbitration.

---
 rtl/apb_rr_master_arb_pkg.sv | 13 +
 rtl/apb_rr_master_arb_rr_picker.sv | 31 +++
 rtl/apb_rr_master_arb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/apb_rr_master_arb_pkg.sv
// Shared types and defaults for the round-robin APB master arbiter.
package apb_rr_master_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_AW_DEF = 32;
    localparam int APB_DW_DEF = 32;

endpackage

// File: rtl/apb_rr_master_arb_rr_picker.sv
// Combinational round-robin picker: first eligible requester after ptr, with wrap.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   cand;

    // Scan farthest-first so the nearest eligible slot after ptr overwrites the rest.
    always_comb begin
        elig  = req & ~mask;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters,
// with IDLE/SETUP/ACCESS sequencing and a wait-state timeout.
module apb_rr_master_arb
    import apb_rr_master_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW_DEF,
    parameter int DW      = APB_DW_DEF,
    parameter int TIMEOUT = 256
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    output logic               PWRITE,
    output logic               PSEL,
    output logic               PENABLE,
    input  logic [DW-1:0]      PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    apb_state_t      state, state_nxt;
    logic [IW-1:0]   gnt_idx, gnt_ptr;
    logic [WCW-1:0]  wait_cnt;
    logic            in_access, tmo, done, load;
    logic            pick_found;
    logic [IW-1:0]   pick_idx, pick_ptr;
    logic [NREQ-1:0] pick_mask;

    // One picker serves both the IDLE pick and the back-to-back re-pick in ACCESS.
    assign in_access = (state == ACCESS);
    assign pick_ptr  = in_access ? gnt_idx : gnt_ptr;
    assign pick_mask = in_access ? (ONE << gnt_idx) : '0;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req   (req_valid),
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign tmo  = (TIMEOUT > 0) && in_access && !PREADY && (wait_cnt == WCW'(TIMEOUT - 1));
    assign done = in_access && (PREADY || tmo);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        req_ready = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (done) begin
                    req_ready = ONE << gnt_idx;
                    rsp_rdata = (PREADY && !PWRITE) ? PRDATA : '0;
                    rsp_err   = PREADY ? PSLVERR : 1'b1;
                    // A timed-out slave always gets an idle cycle before the next grant.
                    if (PREADY && pick_found) begin
                        load      = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            gnt_idx  <= '0;
            gnt_ptr  <= IW'(NREQ - 1);
            PADDR    <= '0;
            PWDATA   <= '0;
            PWRITE   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (load) begin
                gnt_idx <= pick_idx;
                PADDR   <= req_addr[pick_idx*AW +: AW];
                PWDATA  <= req_wdata[pick_idx*DW +: DW];
                PWRITE  <= req_write[pick_idx];
            end
            if (done) gnt_ptr <= gnt_idx;
            if (load)
                wait_cnt <= '0;
            else if (in_access && !PREADY && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule
